pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB).

- Tracks per-stage valid bits and detects load-use hazards.
- Resolves branches and jumps from the EX-stage comparator flags and drives the PC redirect and flushes.
- Registers the EX operand forwarding selects.
- Keeps two event counters for debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- if_valid_i  in  1  fetch presents a real instruction this cycle.
- id_rs1_i, id_rs2_i  in  5  source registers of the ID instruction.
- id_use_rs1_i, id_use_rs2_i  in  1  ID instruction actually reads rs1/rs2.
- ex_rd_i, mem_rd_i  in  5  destination registers in EX and MEM.
- ex_regwen_i, mem_regwen_i  in  1  EX/MEM instruction writes rd.
- ex_memread_i  in  1  EX instruction is a load.
- ex_is_br_i, ex_is_jmp_i  in  1  EX instruction is a conditional branch / JAL or JALR.
- ex_funct3_i  in  3  funct3 of the EX instruction.
- br_eq_i, br_lt_i  in  1  comparator flags for the EX operands.
- br_un_o  out  1  unsigned compare; equals ex_funct3_i[1], combinational.
- pc_sel_o  out  1  1 selects the ALU target as the next PC.
- stall_o  out  1  hold PC and the IF/ID register.
- flush_id_o  out  1  zero the IF/ID register.
- flush_ex_o  out  1  insert a bubble into the ID/EX register.
- fwd_a_o, fwd_b_o  out  2  EX operand source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB writeback data.
- id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o  out  1  stage holds a live instruction.
- stall_cnt_o, flush_cnt_o  out  CNT_W  event counters.

## Operation
Combinational terms:
- taken = ex_valid & (ex_is_jmp_i | ex_is_br_i & cond).
- cond by funct3:
  - 000: eq.
  - 001: !eq.
  - 100 and 110: lt.
  - 101 and 111: !lt.
  - Any other funct3: 0.
- lduse = ex_valid & id_valid & ex_memread_i & ex_rd_i!=0 & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
- Redirect has priority:
  - pc_sel_o = flush_id_o = taken.
  - flush_ex_o = taken | lduse.
  - stall_o = lduse & !taken.

Valid pipeline, updated each clock edge:
- id_valid:
  - 0 if taken.
  - Otherwise held if stall_o.
  - Otherwise if_valid_i.
- ex_valid:
  - 0 if flush_ex_o.
  - Otherwise id_valid.
- mem_valid <= ex_valid.
- wb_valid <= mem_valid.

Forward selects are registered: computed from the ID fields and latched into EX at the edge. Per operand x:
- 00 if the operand is unused, rs is x0, or flush_ex_o.
- Else 01 if ex_valid & ex_regwen_i & !ex_memread_i & rs==ex_rd_i.
- Else 10 if mem_valid & mem_regwen_i & rs==mem_rd_i.
- Else 00.
- The nearer stage wins.

WB is not forwarded; the register file is write-through.

Counters:
- stall_cnt increments on every cycle with stall_o=1.
- flush_cnt increments on every cycle with taken=1.
- Both wrap modulo 2^CNT_W.

## Timing
- Reset:
  - All valid bits, fwd selects and counters are 0.
  - pc_sel_o, stall_o and the flush outputs are 0; ex_valid=0 forces taken and lduse to 0.
- Reset deasserted mid-operation: the pipeline restarts empty. No pending redirect or stall survives reset.
- Redirect: pc_sel_o and the flushes are asserted in the same cycle the branch is in EX. The target is fetched next cycle. Penalty is 2 bubbles.
- Load-use: exactly 1 stall cycle.
  - Next cycle the load is in MEM and lduse is 0.
  - The dependent instruction's fwd select becomes 10.
- Branch in EX and load-use in ID in the same cycle: redirect only. stall_o=0, no stall count.
- Back-to-back taken branches are impossible, because a flushed EX is not valid. Each redirect counts once.
- if_valid_i=0 while not stalled: a bubble enters ID, and no hazard is raised against it.

## Structure
- Shared package `pipe_pkg` holds:
  - fwd_sel_e enum {FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10}.
  - funct3 branch constants (BEQ, BNE, BLT, BGE, BLTU, BGEU).
- One sub-module is natural: `fwd_sel`, combinational per-operand priority logic. It is instantiated twice, for rs1 and rs2.

## Test plan
- Reset with if_valid_i=1 on every cycle: all outputs 0 during reset. After release, id_valid=1 at cycle 1 and wb_valid=1 at cycle 4.
- ADD x5 in EX, SUB reading x5 in ID: fwd_a_o=01 next cycle. One cycle later with x5 in MEM: fwd=10. With rs=x0: fwd=00.
- LW x6 in EX, ADD using x6 in ID:
  - stall_o=1 and flush_ex_o=1 for 1 cycle.
  - The next cycle has ex_valid=0 and fwd=10.
  - stall_cnt increments by 1.
- BLTU in EX with br_lt_i=1, funct3=110:
  - br_un_o=1, pc_sel_o=1, flush_id_o=1, flush_ex_o=1.
  - The next cycle has id_valid=0 and ex_valid=0, and flush_cnt increments by 1.
  - Repeat with BGE and br_lt_i=1: not taken.
- Taken branch in EX together with a load-use in ID: pc_sel_o=1, stall_o=0, stall_cnt unchanged.
- Preload stall_cnt to 16'hFFFF, then trigger a stall: stall_cnt wraps to 0.
- Assert rst_ni mid-stall: valid bits and fwd selects clear immediately (asynchronous reset).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencing logic.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // Branch condition from funct3 and the EX comparator flags; undefined funct3 never branches.
    function automatic logic br_cond(input logic [2:0] funct3, input logic eq, input logic lt);
        logic c;
        c = 1'b0;
        case (funct3)
            BEQ:         c = eq;
            BNE:         c = !eq;
            BLT, BLTU:   c = lt;
            BGE, BGEU:   c = !lt;
            default:     c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Per-operand forwarding source select for the instruction leaving ID.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic       use_i,
    input  logic [4:0] rs_i,
    input  logic       flush_i,
    input  logic       ex_valid_i,
    input  logic       ex_regwen_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rd_i,
    input  logic       mem_valid_i,
    input  logic       mem_regwen_i,
    input  logic [4:0] mem_rd_i,
    output fwd_sel_e   sel_o
);

    logic w_ex_hit;
    logic w_mem_hit;

    always_comb begin
        w_ex_hit  = ex_valid_i & ex_regwen_i & !ex_memread_i & (rs_i == ex_rd_i);
        w_mem_hit = mem_valid_i & mem_regwen_i & (rs_i == mem_rd_i);
        sel_o     = FWD_RF;
        // The current EX instruction is the nearer producer, so it wins over MEM.
        if (!use_i || rs_i == 5'd0 || flush_i) begin
            sel_o = FWD_RF;
        end else if (w_ex_hit) begin
            sel_o = FWD_MEM;
        end else if (w_mem_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing: stage valids, load-use stall, branch redirect, forward selects, debug counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             if_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             ex_regwen_i,
    input  logic             mem_regwen_i,
    input  logic             ex_memread_i,
    input  logic             ex_is_br_i,
    input  logic             ex_is_jmp_i,
    input  logic [2:0]       ex_funct3_i,
    input  logic             br_eq_i,
    input  logic             br_lt_i,
    output logic             br_un_o,
    output logic             pc_sel_o,
    output logic             stall_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             id_valid_o,
    output logic             ex_valid_o,
    output logic             mem_valid_o,
    output logic             wb_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic             r_id_valid;
    logic             r_ex_valid;
    logic             r_mem_valid;
    logic             r_wb_valid;
    fwd_sel_e         r_fwd_a;
    fwd_sel_e         r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_taken;
    logic             w_lduse;
    logic             w_stall;
    logic             w_flush_ex;
    fwd_sel_e         w_fwd_a;
    fwd_sel_e         w_fwd_b;

    always_comb begin
        w_taken = r_ex_valid & (ex_is_jmp_i | (ex_is_br_i & br_cond(ex_funct3_i, br_eq_i, br_lt_i)));
        w_lduse = r_ex_valid & r_id_valid & ex_memread_i & (ex_rd_i != 5'd0)
                & ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) | (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
        // A redirect discards the ID instruction, so a coincident load-use stall is moot.
        w_stall    = w_lduse & !w_taken;
        w_flush_ex = w_taken | w_lduse;
    end

    fwd_sel u_fwd_a (
        .use_i        (id_use_rs1_i),
        .rs_i         (id_rs1_i),
        .flush_i      (w_flush_ex),
        .ex_valid_i   (r_ex_valid),
        .ex_regwen_i  (ex_regwen_i),
        .ex_memread_i (ex_memread_i),
        .ex_rd_i      (ex_rd_i),
        .mem_valid_i  (r_mem_valid),
        .mem_regwen_i (mem_regwen_i),
        .mem_rd_i     (mem_rd_i),
        .sel_o        (w_fwd_a)
    );

    fwd_sel u_fwd_b (
        .use_i        (id_use_rs2_i),
        .rs_i         (id_rs2_i),
        .flush_i      (w_flush_ex),
        .ex_valid_i   (r_ex_valid),
        .ex_regwen_i  (ex_regwen_i),
        .ex_memread_i (ex_memread_i),
        .ex_rd_i      (ex_rd_i),
        .mem_valid_i  (r_mem_valid),
        .mem_regwen_i (mem_regwen_i),
        .mem_rd_i     (mem_rd_i),
        .sel_o        (w_fwd_b)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_id_valid  <= 1'b0;
            r_ex_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_fwd_a     <= FWD_RF;
            r_fwd_b     <= FWD_RF;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_taken) begin
                r_id_valid <= 1'b0;
            end else if (!w_stall) begin
                r_id_valid <= if_valid_i;
            end
            r_ex_valid  <= w_flush_ex ? 1'b0 : r_id_valid;
            r_mem_valid <= r_ex_valid;
            r_wb_valid  <= r_mem_valid;
            r_fwd_a     <= w_fwd_a;
            r_fwd_b     <= w_fwd_b;
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_taken) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign br_un_o     = ex_funct3_i[1];
    assign pc_sel_o    = w_taken;
    assign flush_id_o  = w_taken;
    assign flush_ex_o  = w_flush_ex;
    assign stall_o     = w_stall;
    assign fwd_a_o     = r_fwd_a;
    assign fwd_b_o     = r_fwd_b;
    assign id_valid_o  = r_id_valid;
    assign ex_valid_o  = r_ex_valid;
    assign mem_valid_o = r_mem_valid;
    assign wb_valid_o  = r_wb_valid;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed checks of pipe_hazard_ctrl; counter width reduced so wrap-around is reachable quickly.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          if_valid_i;
    logic [4:0]    id_rs1_i, id_rs2_i;
    logic          id_use_rs1_i, id_use_rs2_i;
    logic [4:0]    ex_rd_i, mem_rd_i;
    logic          ex_regwen_i, mem_regwen_i, ex_memread_i;
    logic          ex_is_br_i, ex_is_jmp_i;
    logic [2:0]    ex_funct3_i;
    logic          br_eq_i, br_lt_i;
    logic          br_un_o, pc_sel_o, stall_o, flush_id_o, flush_ex_o;
    logic [1:0]    fwd_a_o, fwd_b_o;
    logic          id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .if_valid_i   (if_valid_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .ex_rd_i      (ex_rd_i),
        .mem_rd_i     (mem_rd_i),
        .ex_regwen_i  (ex_regwen_i),
        .mem_regwen_i (mem_regwen_i),
        .ex_memread_i (ex_memread_i),
        .ex_is_br_i   (ex_is_br_i),
        .ex_is_jmp_i  (ex_is_jmp_i),
        .ex_funct3_i  (ex_funct3_i),
        .br_eq_i      (br_eq_i),
        .br_lt_i      (br_lt_i),
        .br_un_o      (br_un_o),
        .pc_sel_o     (pc_sel_o),
        .stall_o      (stall_o),
        .flush_id_o   (flush_id_o),
        .flush_ex_o   (flush_ex_o),
        .fwd_a_o      (fwd_a_o),
        .fwd_b_o      (fwd_b_o),
        .id_valid_o   (id_valid_o),
        .ex_valid_o   (ex_valid_o),
        .mem_valid_o  (mem_valid_o),
        .wb_valid_o   (wb_valid_o),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; if_valid_i = 1'b1;
        id_rs1_i = '0; id_rs2_i = '0; id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0;
        ex_rd_i = '0; mem_rd_i = '0; ex_regwen_i = 1'b0; mem_regwen_i = 1'b0;
        ex_memread_i = 1'b0; ex_is_br_i = 1'b0; ex_is_jmp_i = 1'b0;
        ex_funct3_i = '0; br_eq_i = 1'b0; br_lt_i = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_id_valid", id_valid_o, 0);
        chk("rst_ex_valid", ex_valid_o, 0);
        chk("rst_mem_valid", mem_valid_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_fwd_a", fwd_a_o, 0);
        chk("rst_fwd_b", fwd_b_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        chk("rst_flush_cnt", flush_cnt_o, 0);
        chk("rst_pc_sel", pc_sel_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_flush_id", flush_id_o, 0);
        chk("rst_flush_ex", flush_ex_o, 0);

        // Fill the pipeline
        rst_ni = 1'b1;
        tick();
        chk("fill_id_c1", id_valid_o, 1);
        chk("fill_ex_c1", ex_valid_o, 0);
        tick(); tick();
        chk("fill_mem_c3", mem_valid_o, 1);
        chk("fill_wb_c3", wb_valid_o, 0);
        tick();
        chk("fill_wb_c4", wb_valid_o, 1);

        // ALU forwarding: x5 in EX, then in MEM
        ex_rd_i = 5'd5; ex_regwen_i = 1'b1;
        id_rs1_i = 5'd5; id_use_rs1_i = 1'b1; id_rs2_i = 5'd7; id_use_rs2_i = 1'b1;
        #1 chk("fwd_no_stall", stall_o, 0);
        tick();
        chk("fwd_a_ex", fwd_a_o, 2'b01);
        chk("fwd_b_nomatch", fwd_b_o, 2'b00);
        ex_rd_i = 5'd0; ex_regwen_i = 1'b0; mem_rd_i = 5'd5; mem_regwen_i = 1'b1;
        tick();
        chk("fwd_a_mem", fwd_a_o, 2'b10);
        ex_rd_i = 5'd5; ex_regwen_i = 1'b1; id_rs2_i = 5'd5;
        tick();
        chk("fwd_b_nearer", fwd_b_o, 2'b01);
        id_rs1_i = 5'd0; ex_rd_i = 5'd0; mem_rd_i = 5'd0;
        tick();
        chk("fwd_a_x0", fwd_a_o, 2'b00);
        ex_regwen_i = 1'b0; mem_regwen_i = 1'b0;
        id_rs1_i = '0; id_rs2_i = '0; id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0;

        // Load-use: LW x6 in EX, consumer reads x6 through rs2
        ex_memread_i = 1'b1; ex_rd_i = 5'd6; ex_regwen_i = 1'b1;
        id_rs2_i = 5'd6; id_use_rs2_i = 1'b1;
        #1;
        chk("lu_stall", stall_o, 1);
        chk("lu_flush_ex", flush_ex_o, 1);
        chk("lu_flush_id", flush_id_o, 0);
        chk("lu_pc_sel", pc_sel_o, 0);
        tick();
        chk("lu_ex_bubble", ex_valid_o, 0);
        chk("lu_id_held", id_valid_o, 1);
        chk("lu_stall_cnt", stall_cnt_o, 1);
        chk("lu_fwd_b_flushed", fwd_b_o, 2'b00);
        ex_memread_i = 1'b0; ex_rd_i = 5'd0; ex_regwen_i = 1'b0;
        mem_rd_i = 5'd6; mem_regwen_i = 1'b1;
        #1 chk("lu_single_stall", stall_o, 0);
        tick();
        chk("lu_fwd_b_wb", fwd_b_o, 2'b10);
        chk("lu_ex_valid", ex_valid_o, 1);
        chk("lu_stall_cnt_hold", stall_cnt_o, 1);
        id_rs2_i = '0; id_use_rs2_i = 1'b0; mem_rd_i = '0; mem_regwen_i = 1'b0;

        // BLTU taken
        ex_is_br_i = 1'b1; ex_funct3_i = 3'b110; br_lt_i = 1'b1;
        #1;
        chk("bltu_br_un", br_un_o, 1);
        chk("bltu_pc_sel", pc_sel_o, 1);
        chk("bltu_flush_id", flush_id_o, 1);
        chk("bltu_flush_ex", flush_ex_o, 1);
        chk("bltu_stall", stall_o, 0);
        tick();
        chk("bltu_id_flushed", id_valid_o, 0);
        chk("bltu_ex_flushed", ex_valid_o, 0);
        chk("bltu_flush_cnt", flush_cnt_o, 1);
        ex_is_br_i = 1'b0; ex_funct3_i = '0; br_lt_i = 1'b0;
        tick();
        chk("redir_id_refill", id_valid_o, 1);
        chk("redir_ex_bubble2", ex_valid_o, 0);
        tick();
        chk("redir_ex_refill", ex_valid_o, 1);

        // BGE with lt=1: not taken
        ex_is_br_i = 1'b1; ex_funct3_i = 3'b101; br_lt_i = 1'b1;
        #1;
        chk("bge_pc_sel", pc_sel_o, 0);
        chk("bge_br_un", br_un_o, 0);
        chk("bge_flush_ex", flush_ex_o, 0);
        tick();
        chk("bge_flush_cnt", flush_cnt_o, 1);
        chk("bge_ex_valid", ex_valid_o, 1);
        ex_funct3_i = 3'b010; br_eq_i = 1'b1;
        #1 chk("f3_010_pc_sel", pc_sel_o, 0);

        // Taken BEQ together with a load-use in ID
        ex_funct3_i = 3'b000; br_eq_i = 1'b1; br_lt_i = 1'b0;
        ex_memread_i = 1'b1; ex_rd_i = 5'd6; ex_regwen_i = 1'b1;
        id_rs1_i = 5'd6; id_use_rs1_i = 1'b1;
        #1;
        chk("both_pc_sel", pc_sel_o, 1);
        chk("both_stall", stall_o, 0);
        chk("both_flush_ex", flush_ex_o, 1);
        tick();
        chk("both_stall_cnt", stall_cnt_o, 1);
        chk("both_flush_cnt", flush_cnt_o, 2);
        chk("both_id_flushed", id_valid_o, 0);
        ex_is_br_i = 1'b0; br_eq_i = 1'b0;
        ex_memread_i = 1'b0; ex_rd_i = '0; ex_regwen_i = 1'b0;
        tick(); tick();
        chk("both_ex_refill", ex_valid_o, 1);

        // Stall counter wrap: 1 + 14 stalls = 15, one more wraps to 0
        for (int i = 0; i < 15; i++) begin
            if (i == 14) chk("wrap_cnt_max", stall_cnt_o, 15);
            ex_memread_i = 1'b1; ex_rd_i = 5'd6; ex_regwen_i = 1'b1;
            mem_rd_i = '0; mem_regwen_i = 1'b0;
            tick();
            ex_memread_i = 1'b0; ex_rd_i = '0; ex_regwen_i = 1'b0;
            mem_rd_i = 5'd6; mem_regwen_i = 1'b1;
            if (i == 14) chk("wrap_cnt_zero", stall_cnt_o, 0);
            tick();
        end
        chk("pre_rst_fwd_a", fwd_a_o, 2'b10);

        // Asynchronous reset in the middle of a stall
        ex_memread_i = 1'b1; ex_rd_i = 5'd6; ex_regwen_i = 1'b1;
        mem_rd_i = '0; mem_regwen_i = 1'b0;
        #1 chk("pre_rst_stall", stall_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_id_valid", id_valid_o, 0);
        chk("arst_ex_valid", ex_valid_o, 0);
        chk("arst_mem_valid", mem_valid_o, 0);
        chk("arst_fwd_a", fwd_a_o, 2'b00);
        chk("arst_stall", stall_o, 0);
        chk("arst_stall_cnt", stall_cnt_o, 0);
        chk("arst_flush_cnt", flush_cnt_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("restart_id", id_valid_o, 1);
        chk("restart_ex", ex_valid_o, 0);
        chk("restart_no_stall", stall_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
